// File: rtl/pattern_detector_prog_if.sv
// Stream, configuration and match-handshake bundle for pattern_detector_prog.
// The master side is the byte-stream source / control FSM; the slave side is the detector.
interface pattern_detector_prog_if #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [DATA_W-1:0] cfg_char;
    logic              cfg_len_we;
    logic [LEN_W-1:0]  cfg_len;
    logic              overlap_en;
    logic              ack;
    logic              found_pattern;
    logic              overflow;
    logic [CNT_W-1:0]  match_count;

    modport master (
        output data, data_valid, cfg_we, cfg_idx, cfg_char,
               cfg_len_we, cfg_len, overlap_en, ack,
        input  found_pattern, overflow, match_count
    );

    modport slave (
        input  data, data_valid, cfg_we, cfg_idx, cfg_char,
               cfg_len_we, cfg_len, overlap_en, ack,
        output found_pattern, overflow, match_count
    );
endinterface

// File: rtl/pattern_detector_prog.sv
// Programmable pattern detector: matches a runtime-loaded pattern of 1..MAX_LEN
// symbols against a qualified stream, queues matches as pending events that the
// consumer acknowledges one per ack cycle, and keeps a wrapping match count.
module pattern_detector_prog #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 8,
    parameter int PEND_W  = 3,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_sync,
    pattern_detector_prog_if.slave bus
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [DATA_W-1:0] pattern [MAX_LEN];
    logic [DATA_W-1:0] history [MAX_LEN];
    logic [DATA_W-1:0] window  [MAX_LEN];
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  fill;
    logic [LEN_W-1:0]  fill_inc;
    logic [LEN_W-1:0]  pat_idx;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_next;
    logic              found_q;
    logic              overflow_q;
    logic              overflow_set;
    logic [CNT_W-1:0]  count_q;
    logic              cfg_write;
    logic              match_ok;
    logic              match_hit;

    assign cfg_write         = bus.cfg_we | bus.cfg_len_we;
    assign match_hit         = bus.data_valid & ~cfg_write & match_ok;
    assign fill_inc          = (fill == LEN_MAX) ? fill : fill + 1'b1;
    assign bus.found_pattern = found_q;
    assign bus.overflow      = overflow_q;
    assign bus.match_count   = count_q;

    // Compare the incoming symbol plus the newest len-1 history symbols against the pattern, newest symbol against its last slot
    always_comb begin
        window[0] = bus.data;
        for (int i = 1; i < MAX_LEN; i++) begin
            window[i] = history[i-1];
        end
        pat_idx  = '0;
        match_ok = (len != '0) && (({1'b0, fill} + 1'b1) >= {1'b0, len});
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len) begin
                pat_idx = len - 1'b1 - LEN_W'(i);
                if (window[i] != pattern[pat_idx[IDX_W-1:0]]) begin
                    match_ok = 1'b0;
                end
            end
        end
    end

    // Work out the pending-event count after this edge, flagging a match lost to saturation
    always_comb begin
        pending_next = pending;
        overflow_set = 1'b0;
        if (match_hit && !bus.ack) begin
            if (pending == PEND_MAX) begin
                overflow_set = 1'b1;
            end else begin
                pending_next = pending + 1'b1;
            end
        end else if (match_hit && bus.ack) begin
            if (pending == '0) begin
                pending_next = PEND_W'(1);
            end
        end else if (bus.ack && pending != '0) begin
            pending_next = pending - 1'b1;
        end
    end

    // Load pattern slots and the clamped pattern length from the configuration port
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                pattern[i] <= '0;
            end
            len <= '0;
        end else begin
            if (bus.cfg_we && (int'(bus.cfg_idx) < MAX_LEN)) begin
                pattern[bus.cfg_idx] <= bus.cfg_char;
            end
            if (bus.cfg_len_we) begin
                len <= (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
            end
        end
    end

    // Shift accepted symbols into history and track how many arrived since the last clear
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                history[i] <= '0;
            end
            fill <= '0;
        end else if (cfg_write) begin
            fill <= '0;
        end else if (bus.data_valid) begin
            history[0] <= bus.data;
            for (int i = 1; i < MAX_LEN; i++) begin
                history[i] <= history[i-1];
            end
            if (match_hit && !bus.overlap_en) begin
                fill <= '0;
            end else begin
                fill <= fill_inc;
            end
        end
    end

    // Register the pending queue, the found flag, sticky overflow and the match counter
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            pending    <= '0;
            found_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pending <= pending_next;
            found_q <= (pending_next != '0);
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
            if (match_hit) begin
                count_q <= count_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pattern_detector_prog.sv
// Self-checking bench for pattern_detector_prog: table-driven vectors, hand-written
// multi-cycle sequences and a randomized run checked against a queue-based model.
module tb_pattern_detector_prog;
    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 8;
    localparam int PEND_W  = 3;
    localparam int CNT_W   = 16;

    typedef struct {
        logic       valid;
        logic [7:0] d;
        logic       ack;
        logic       cfg_we;
        logic [2:0] idx;
        logic [7:0] ch;
        logic       len_we;
        logic [3:0] len;
    } stim_t;

    typedef struct {
        logic [7:0] d;
        logic       expFound;
        int         expCount;
    } vec_t;

    logic clk;
    logic reset_sync;
    int   checks;
    int   failures;

    // Reference model state: symbols accepted since the last clear, newest at the back
    logic [7:0] mQ[$];
    logic [7:0] mPat[MAX_LEN];
    int         mLen;
    int         mPend;
    int         mCount;
    bit         mOvf;

    pattern_detector_prog_if #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    pattern_detector_prog #(
        .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .PEND_W(PEND_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_sync(reset_sync),
        .bus(bus.slave)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idleStim(logic a);
        stim_t s;
        s = '{default: '0};
        s.d = 8'h62;
        s.ack = a;
        return s;
    endfunction

    function automatic stim_t symStim(logic [7:0] d, logic a);
        stim_t s;
        s = '{default: '0};
        s.valid = 1'b1;
        s.d = d;
        s.ack = a;
        return s;
    endfunction

    task automatic modelReset();
        mQ.delete();
        for (int i = 0; i < MAX_LEN; i++) mPat[i] = 8'h00;
        mLen = 0;
        mPend = 0;
        mCount = 0;
        mOvf = 0;
    endtask

    task automatic modelStep(stim_t s);
        bit hit;
        hit = 0;
        if (s.cfg_we || s.len_we) begin
            if (s.cfg_we) mPat[s.idx] = s.ch;
            if (s.len_we) mLen = (int'(s.len) > MAX_LEN) ? MAX_LEN : int'(s.len);
            mQ.delete();
        end else if (s.valid) begin
            mQ.push_back(s.d);
            if (mQ.size() > MAX_LEN) void'(mQ.pop_front());
            if (mLen != 0 && mQ.size() >= mLen) begin
                hit = 1;
                for (int k = 0; k < mLen; k++) begin
                    if (mQ[mQ.size() - mLen + k] != mPat[k]) hit = 0;
                end
            end
            if (hit) begin
                mCount = (mCount + 1) % (1 << CNT_W);
                if (!bus.overlap_en) mQ.delete();
            end
        end
        if (hit && !s.ack) begin
            if (mPend == (1 << PEND_W) - 1) mOvf = 1;
            else mPend++;
        end else if (hit && s.ack) begin
            if (mPend == 0) mPend = 1;
        end else if (s.ack && mPend > 0) begin
            mPend--;
        end
    endtask

    task automatic expectInt(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        expectInt({tag, " found"}, int'(bus.found_pattern), (mPend > 0) ? 1 : 0);
        expectInt({tag, " overflow"}, int'(bus.overflow), int'(mOvf));
        expectInt({tag, " count"}, int'(bus.match_count), mCount);
    endtask

    task automatic applyStimulus(stim_t s, string tag);
        bus.data_valid = s.valid;
        bus.data       = s.d;
        bus.ack        = s.ack;
        bus.cfg_we     = s.cfg_we;
        bus.cfg_idx    = s.idx;
        bus.cfg_char   = s.ch;
        bus.cfg_len_we = s.len_we;
        bus.cfg_len    = s.len;
        @(posedge clk);
        modelStep(s);
        #1;
        bus.data_valid = 1'b0;
        bus.ack        = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_len_we = 1'b0;
        checkOutput(tag);
    endtask

    // Reset with every other input asserted, to show reset wins
    task automatic doReset();
        reset_sync     = 1'b1;
        bus.data_valid = 1'b1;
        bus.data       = 8'h62;
        bus.ack        = 1'b1;
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = 3'd0;
        bus.cfg_char   = 8'h62;
        bus.cfg_len_we = 1'b1;
        bus.cfg_len    = 4'd1;
        @(posedge clk);
        modelReset();
        #1;
        reset_sync     = 1'b0;
        bus.data_valid = 1'b0;
        bus.ack        = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_len_we = 1'b0;
        checkOutput("reset");
    endtask

    task automatic writeSlot(int idx, logic [7:0] ch);
        stim_t s;
        s = idleStim(1'b0);
        s.cfg_we = 1'b1;
        s.idx = 3'(idx);
        s.ch = ch;
        applyStimulus(s, "cfg slot");
    endtask

    task automatic writeLen(int l);
        stim_t s;
        s = idleStim(1'b0);
        s.len_we = 1'b1;
        s.len = 4'(l);
        applyStimulus(s, "cfg len");
    endtask

    task automatic configBoab();
        writeSlot(0, 8'd98);
        writeSlot(1, 8'd111);
        writeSlot(2, 8'd97);
        writeSlot(3, 8'd98);
        writeLen(4);
    endtask

    task automatic feed(string str, logic ackLast, string tag);
        for (int i = 0; i < str.len(); i++) begin
            applyStimulus(symStim(str[i], (i == str.len() - 1) ? ackLast : 1'b0), tag);
        end
    endtask

    task automatic ackCycle(string tag);
        applyStimulus(idleStim(1'b1), tag);
    endtask

    vec_t tbl[7];

    initial begin
        checks = 0;
        failures = 0;
        reset_sync = 1'b1;
        bus.data = '0;
        bus.data_valid = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_char = '0;
        bus.cfg_len_we = 1'b0;
        bus.cfg_len = '0;
        bus.overlap_en = 1'b1;
        bus.ack = 1'b0;
        modelReset();

        tbl[0] = '{8'd98,  1'b0, 0};
        tbl[1] = '{8'd111, 1'b0, 0};
        tbl[2] = '{8'd97,  1'b0, 0};
        tbl[3] = '{8'd98,  1'b1, 1};
        tbl[4] = '{8'd111, 1'b1, 1};
        tbl[5] = '{8'd97,  1'b1, 1};
        tbl[6] = '{8'd98,  1'b1, 2};

        // Reset state
        doReset();
        expectInt("reset found", int'(bus.found_pattern), 0);
        expectInt("reset overflow", int'(bus.overflow), 0);
        expectInt("reset count", int'(bus.match_count), 0);

        // Overlapping "boaboab" from the vector table
        configBoab();
        bus.overlap_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(symStim(tbl[i].d, 1'b0), $sformatf("tbl%0d", i));
            expectInt($sformatf("tbl%0d found", i), int'(bus.found_pattern), int'(tbl[i].expFound));
            expectInt($sformatf("tbl%0d count", i), int'(bus.match_count), tbl[i].expCount);
        end

        // Non-overlapping: the same stream yields one match
        doReset();
        configBoab();
        bus.overlap_en = 1'b0;
        feed("boaboab", 1'b0, "nonovl");
        expectInt("nonovl count", int'(bus.match_count), 1);
        expectInt("nonovl found", int'(bus.found_pattern), 1);

        // Three queued matches drained by acks, then match+ack interactions
        doReset();
        configBoab();
        bus.overlap_en = 1'b1;
        feed("boaboaboab", 1'b0, "queue3");
        expectInt("queue3 count", int'(bus.match_count), 3);
        ackCycle("ack1");
        expectInt("ack1 found", int'(bus.found_pattern), 1);
        ackCycle("ack2");
        expectInt("ack2 found", int'(bus.found_pattern), 1);
        ackCycle("ack3");
        expectInt("ack3 found", int'(bus.found_pattern), 0);
        ackCycle("ack4");
        expectInt("ack4 found", int'(bus.found_pattern), 0);
        expectInt("ack4 count", int'(bus.match_count), 3);
        feed("oaboab", 1'b0, "requeue");
        feed("oab", 1'b1, "matchack2");
        expectInt("matchack2 count", int'(bus.match_count), 6);
        ackCycle("drain1");
        expectInt("drain1 found", int'(bus.found_pattern), 1);
        ackCycle("drain2");
        expectInt("drain2 found", int'(bus.found_pattern), 0);
        feed("oab", 1'b1, "matchack0");
        expectInt("matchack0 found", int'(bus.found_pattern), 1);
        ackCycle("drain3");
        expectInt("drain3 found", int'(bus.found_pattern), 0);

        // Pending saturation and sticky overflow
        doReset();
        configBoab();
        feed("b", 1'b0, "sat");
        for (int i = 0; i < 7; i++) feed("oab", 1'b0, "sat");
        expectInt("sat7 overflow", int'(bus.overflow), 0);
        feed("oab", 1'b0, "sat");
        expectInt("sat8 overflow", int'(bus.overflow), 1);
        expectInt("sat8 count", int'(bus.match_count), 8);
        for (int i = 0; i < 6; i++) ackCycle("satdrain");
        expectInt("satdrain6 found", int'(bus.found_pattern), 1);
        ackCycle("satdrain");
        expectInt("satdrain7 found", int'(bus.found_pattern), 0);
        expectInt("satdrain7 overflow", int'(bus.overflow), 1);

        // Config write clears fill and drops the same-cycle symbol
        doReset();
        configBoab();
        feed("boa", 1'b0, "cfgclr");
        begin
            stim_t s;
            s = symStim(8'd98, 1'b0);
            s.cfg_we = 1'b1;
            s.idx = 3'd0;
            s.ch = 8'd98;
            applyStimulus(s, "cfgclr write");
        end
        feed("b", 1'b0, "cfgclr");
        expectInt("cfgclr count", int'(bus.match_count), 0);
        feed("oab", 1'b0, "cfgclr");
        expectInt("cfgclr refill count", int'(bus.match_count), 1);

        // Length 9 clamps to 8
        for (int i = 0; i < MAX_LEN; i++) writeSlot(i, 8'(8'd97 + i));
        writeLen(9);
        feed("abcdefgh", 1'b0, "clamp");
        expectInt("clamp count", int'(bus.match_count), 2);

        // Length 0 disables detection
        writeLen(0);
        for (int i = 0; i < 30; i++) applyStimulus(symStim(8'(8'd97 + $urandom_range(0, 7)), 1'b0), "len0");
        feed("abcdefgh", 1'b0, "len0");
        expectInt("len0 count", int'(bus.match_count), 2);

        // data_valid gaps do not break a match
        doReset();
        configBoab();
        feed("bo", 1'b0, "gap");
        for (int i = 0; i < 5; i++) applyStimulus(idleStim(1'b0), "gap idle");
        feed("ab", 1'b0, "gap");
        expectInt("gap count", int'(bus.match_count), 1);
        expectInt("gap found", int'(bus.found_pattern), 1);

        // Reset in the middle of a handshake with two pending events
        feed("oab", 1'b0, "midrst");
        expectInt("midrst pre count", int'(bus.match_count), 2);
        doReset();
        expectInt("midrst found", int'(bus.found_pattern), 0);
        expectInt("midrst count", int'(bus.match_count), 0);
        feed("boab", 1'b0, "midrst post");
        expectInt("midrst len0 count", int'(bus.match_count), 0);

        // Randomized run against the model
        doReset();
        for (int i = 0; i < 4; i++) writeSlot(i, 8'(8'h61 + $urandom_range(0, 1)));
        writeLen($urandom_range(1, 4));
        for (int n = 0; n < 2000; n++) begin
            stim_t s;
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                doReset();
            end else begin
                if (r < 3) bus.overlap_en = ~bus.overlap_en;
                s = symStim(8'(8'h61 + $urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
                s.valid = 1'($urandom_range(0, 3) != 0);
                if (r >= 190) begin
                    s.cfg_we = 1'b1;
                    s.idx = 3'($urandom_range(0, 3));
                    s.ch = 8'(8'h61 + $urandom_range(0, 1));
                end else if (r >= 184) begin
                    s.len_we = 1'b1;
                    s.len = 4'($urandom_range(0, 12));
                end
                applyStimulus(s, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
